dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge.sv | 178 +++++++++++++++++
 tb/tb_dmem_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns a single-cycle MEM-stage access into a valid/ready bus request, stalls
// the core until the response (or a timeout) retires it, and discards responses that belong
// to accesses already abandoned by a timeout.
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // core side
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [7:0]  core_be_i,
  input  logic [63:0] core_addr_i,
  input  logic [63:0] core_wdata_i,
  output logic [63:0] core_rdata_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  // bus request channel
  output logic        bus_req_valid_o,
  input  logic        bus_req_ready_i,
  output logic        bus_we_o,
  output logic [7:0]  bus_be_o,
  output logic [63:0] bus_addr_o,
  output logic [63:0] bus_wdata_o,
  // bus response channel (no backpressure)
  input  logic        bus_rsp_valid_i,
  input  logic        bus_rsp_err_i,
  input  logic [63:0] bus_rsp_rdata_i
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  // Counter holds the number of ISSUE/WAIT cycles already spent; the window closes at the end
  // of the cycle in which it would reach TIMEOUT_CYCLES.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [7:0]  be_q, be_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        stale_q, stale_d;

  logic        expired;
  logic [15:0] cnt_inc;

  assign expired = (cnt_q >= TimeoutLast);
  // Saturate so a pathological parameter can never wrap the counter back below the limit.
  assign cnt_inc = (cnt_q != 16'hffff) ? cnt_q + 16'd1 : cnt_q;

  // Next-state, payload capture, completion capture and combinational core/bus strobes.
  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    be_d            = be_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    cnt_d           = cnt_q;
    stale_d         = stale_q;
    bus_req_valid_o = 1'b0;
    core_stall_o    = 1'b0;

    // A response owed to an abandoned access is swallowed wherever it shows up.
    if (bus_rsp_valid_i && stale_q) begin
      stale_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        core_stall_o = core_req_i;
        if (core_req_i) begin
          we_d    = core_we_i;
          be_d    = core_be_i;
          addr_d  = core_addr_i;
          wdata_d = core_wdata_i;
          cnt_d   = 16'd0;
          state_d = StIssue;
        end
      end

      StIssue: begin
        core_stall_o    = 1'b1;
        bus_req_valid_o = 1'b1;
        cnt_d           = cnt_inc;
        // Acceptance beats expiry; a response seen here is never this access's completion.
        if (bus_req_ready_i) begin
          state_d = StWait;
        end else if (expired) begin
          rdata_d = 64'd0;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end

      StWait: begin
        core_stall_o = 1'b1;
        cnt_d        = cnt_inc;
        if (bus_rsp_valid_i && !stale_q) begin
          rdata_d = we_q ? 64'd0 : bus_rsp_rdata_i;
          err_d   = bus_rsp_err_i;
          state_d = StDone;
        end else if (expired) begin
          // The bus still owes a response for this access; remember to drop it.
          rdata_d = 64'd0;
          err_d   = 1'b1;
          stale_d = 1'b1;
          state_d = StDone;
        end
      end

      StDone: begin
        // One-cycle retire window; a still-high request is the next access, taken from IDLE.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (rst) begin
      core_stall_o = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      be_q    <= 8'd0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  assign bus_we_o     = we_q;
  assign bus_be_o     = be_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;
  assign core_rdata_o = rdata_q;
  assign core_err_o   = err_q;

  // Valid may only fall through acceptance or expiry, with the payload frozen meanwhile.
  a_valid_hold: assert property (@(posedge clk) disable iff (rst)
    (bus_req_valid_o && !bus_req_ready_i && !expired) |=> bus_req_valid_o);

  a_payload_stable: assert property (@(posedge clk) disable iff (rst)
    (bus_req_valid_o && !bus_req_ready_i && !expired) |=>
      ($stable(bus_addr_o) && $stable(bus_wdata_o) && $stable(bus_be_o) && $stable(bus_we_o)));

  a_no_stall_in_reset: assert property (@(posedge clk) rst |-> !core_stall_o);

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomised bench for dmem_bridge. A driver plans each access (ready delay, response delay)
// and pushes the predicted outcome; independent monitors check the bus and core sides.
module tb_dmem_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_i, core_we_i;
  logic [7:0]  core_be_i;
  logic [63:0] core_addr_i, core_wdata_i;
  logic [63:0] core_rdata_o;
  logic        core_stall_o, core_err_o;
  logic        bus_req_valid_o, bus_req_ready_i;
  logic        bus_we_o;
  logic [7:0]  bus_be_o;
  logic [63:0] bus_addr_o, bus_wdata_o;
  logic        bus_rsp_valid_i, bus_rsp_err_i;
  logic [63:0] bus_rsp_rdata_i;

  dmem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .core_req_i     (core_req_i),
    .core_we_i      (core_we_i),
    .core_be_i      (core_be_i),
    .core_addr_i    (core_addr_i),
    .core_wdata_i   (core_wdata_i),
    .core_rdata_o   (core_rdata_o),
    .core_stall_o   (core_stall_o),
    .core_err_o     (core_err_o),
    .bus_req_valid_o(bus_req_valid_o),
    .bus_req_ready_i(bus_req_ready_i),
    .bus_we_o       (bus_we_o),
    .bus_be_o       (bus_be_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rsp_valid_i(bus_rsp_valid_i),
    .bus_rsp_err_i  (bus_rsp_err_i),
    .bus_rsp_rdata_i(bus_rsp_rdata_i)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {longint c; logic [63:0] d; logic e;} rsp_t;
  typedef struct {logic [63:0] rdata; logic err; int stall;} exp_t;
  typedef struct {logic we; logic [7:0] be; logic [63:0] addr; logic [63:0] wdata; bit acc;} req_t;

  rsp_t   sched[$];
  longint last_sched_c = -1;
  exp_t   exp_q[$];
  req_t   bus_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Present whatever response the bus model has scheduled for the current cycle.
  task automatic drive_rsp();
    bus_rsp_valid_i = 1'b0;
    bus_rsp_rdata_i = r64();
    bus_rsp_err_i   = 1'($urandom_range(0, 1));
    if (sched.size() > 0 && sched[0].c <= cyc) begin
      bus_rsp_valid_i = (sched[0].c == cyc);
      bus_rsp_rdata_i = sched[0].d;
      bus_rsp_err_i   = sched[0].e;
      void'(sched.pop_front());
    end
  endtask

  task automatic scramble_core();
    core_we_i    = 1'($urandom_range(0, 1));
    core_be_i    = 8'($urandom);
    core_addr_i  = r64();
    core_wdata_i = r64();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rst             = 1'b0;
      core_req_i      = 1'b0;
      bus_req_ready_i = 1'($urandom_range(0, 1));
      scramble_core();
      drive_rsp();
    end
  endtask

  task automatic drain();
    while (sched.size() > 0) idle(1);
    idle(2);
  endtask

  // One access: ready after r ISSUE cycles (never if r >= TO), response k cycles after the
  // first WAIT cycle. The outcome follows from the time budget alone: the access completes
  // normally if it is sampled within max(TO, r+2) ISSUE+WAIT cycles, else it times out.
  task automatic do_txn(input logic we, input logic [7:0] be, input logic [63:0] addr,
                        input logic [63:0] wdata, input int r, input int k_in, input bit echo,
                        input bit hold, input logic [63:0] rsp_d, input logic rsp_e);
    longint n, acc;
    int     k, w, stall;
    bit     normal;
    rsp_t   s;
    exp_t   x;
    req_t   q;
    @(negedge clk);
    n               = cyc;
    core_req_i      = 1'b1;
    core_we_i       = we;
    core_be_i       = be;
    core_addr_i     = addr;
    core_wdata_i    = wdata;
    bus_req_ready_i = 1'b0;
    drive_rsp();
    k = k_in;
    if (r < TO) begin
      acc = n + 1 + r;
      if (echo && last_sched_c < acc) begin
        s.c = acc; s.d = r64(); s.e = 1'($urandom_range(0, 1));
        sched.push_back(s);
        last_sched_c = acc;
      end
      // The bus answers in order: this response follows any earlier one still owed.
      if (acc + 1 + k <= last_sched_c) k = int'(last_sched_c - acc);
      s.c = acc + 1 + k; s.d = rsp_d; s.e = rsp_e;
      sched.push_back(s);
      last_sched_c = s.c;
      w      = (TO > r + 2) ? TO : r + 2;
      normal = (r + k + 2 <= w);
      stall  = normal ? r + k + 3 : w + 1;
    end else begin
      acc    = -1;
      normal = 1'b0;
      stall  = TO + 1;
    end
    x.rdata = normal ? (we ? 64'd0 : rsp_d) : 64'd0;
    x.err   = normal ? rsp_e : 1'b1;
    x.stall = stall;
    exp_q.push_back(x);
    q.we = we; q.be = be; q.addr = addr; q.wdata = wdata; q.acc = (r < TO);
    bus_q.push_back(q);
    repeat (stall) begin
      @(negedge clk);
      core_req_i = hold;
      if (!hold) scramble_core();
      bus_req_ready_i = (cyc == acc);
      drive_rsp();
    end
  endtask

  task automatic rnd_txn(input bit hold);
    int r, k;
    r = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 10));
    k = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 10));
    do_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
           r64(), r64(), r, k, ($urandom_range(0, 3) == 0), hold, r64(),
           ($urandom_range(0, 3) == 0));
  endtask

  // Monitor: sampled late in each cycle, after the driver has settled the inputs.
  int          stall_cnt = 0;
  bit          prev_rst  = 1'b0;
  bit          pv_nohs   = 1'b0;
  logic [63:0] last_rd   = 64'd0;
  logic        last_err  = 1'b0;

  always @(negedge clk) begin
    exp_t x;
    bit   done;
    #2;
    done = 1'b0;
    if (rst) begin
      chk("stall_in_reset", 64'(core_stall_o), 64'd0);
      stall_cnt = 0;
      last_rd   = 64'd0;
      last_err  = 1'b0;
      pv_nohs   = 1'b0;
      prev_rst  = 1'b1;
    end else begin
      if (prev_rst) chk("valid_after_reset", 64'(bus_req_valid_o), 64'd0);
      prev_rst = 1'b0;
      if (bus_req_valid_o) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bus_req at cycle %0d: got addr %h expected no request",
                   cyc, bus_addr_o);
        end else begin
          chk("bus_we", 64'(bus_we_o), 64'(bus_q[0].we));
          chk("bus_be", 64'(bus_be_o), 64'(bus_q[0].be));
          chk("bus_addr", bus_addr_o, bus_q[0].addr);
          chk("bus_wdata", bus_wdata_o, bus_q[0].wdata);
          if (bus_req_ready_i) begin
            chk("accept_planned", 64'(bus_q[0].acc), 64'd1);
            void'(bus_q.pop_front());
            pv_nohs = 1'b0;
          end else begin
            pv_nohs = 1'b1;
          end
        end
      end else begin
        if (pv_nohs && bus_q.size() > 0) begin
          chk("valid_drop_is_issue_timeout", 64'(bus_q[0].acc), 64'd0);
          void'(bus_q.pop_front());
        end
        pv_nohs = 1'b0;
      end
      if (core_stall_o) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done at cycle %0d: got rdata %h expected no completion",
                   cyc, core_rdata_o);
        end else begin
          x = exp_q.pop_front();
          chk("done_rdata", core_rdata_o, x.rdata);
          chk("done_err", 64'(core_err_o), 64'(x.err));
          chk("stall_cycles", 64'(stall_cnt), 64'(x.stall));
          last_rd  = x.rdata;
          last_err = x.err;
        end
        stall_cnt = 0;
      end
      if (!done) begin
        chk("rdata_hold", core_rdata_o, last_rd);
        chk("err_hold", 64'(core_err_o), 64'(last_err));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    longint n;
    rsp_t   s;
    bit     hold;
    rst = 1'b1; core_req_i = 1'b0; bus_req_ready_i = 1'b0;
    scramble_core();
    bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0; bus_rsp_rdata_i = 64'd0;
    repeat (3) begin
      @(negedge clk);
      rst = 1'b1;
      drive_rsp();
    end
    idle(2);

    // Minimum-latency load.
    do_txn(1'b0, 8'hff, 64'h80, r64(), 0, 0, 1'b0, 1'b0, 64'hdeadbeef_cafef00d, 1'b0);
    idle(1);
    // Store with ready held off for 5 cycles; then a store with no byte enables.
    do_txn(1'b1, 8'h0f, r64(), r64(), 5, 0, 1'b0, 1'b0, r64(), 1'b0);
    do_txn(1'b1, 8'h00, r64(), r64(), 1, 2, 1'b0, 1'b0, r64(), 1'b0);
    // Never accepted: ISSUE timeout, then a normal load.
    do_txn(1'b0, 8'hff, r64(), r64(), 100, 0, 1'b0, 1'b0, r64(), 1'b0);
    do_txn(1'b0, 8'hff, r64(), r64(), 0, 0, 1'b0, 1'b0, 64'h1111_2222_3333_4444, 1'b0);
    idle(1);
    // Accepted, response 12 cycles after the request: timeout; stale reply lands in the
    // next access's WAIT and must not complete it.
    do_txn(1'b0, 8'hff, r64(), r64(), 0, 10, 1'b0, 1'b0, 64'h5555_5555_5555_5555, 1'b0);
    do_txn(1'b0, 8'hff, r64(), r64(), 0, 0, 1'b0, 1'b0, 64'h0123_4567_89ab_cdef, 1'b0);
    drain();
    // Back-to-back loads with the request held high through DONE.
    do_txn(1'b0, 8'hff, r64(), r64(), 0, 0, 1'b0, 1'b1, r64(), 1'b0);
    do_txn(1'b0, 8'hff, r64(), r64(), 0, 0, 1'b0, 1'b0, r64(), 1'b1);
    // Ready on the last ISSUE cycle, with and without an immediate response.
    do_txn(1'b0, 8'hff, r64(), r64(), TO - 1, 0, 1'b0, 1'b0, r64(), 1'b0);
    drain();
    do_txn(1'b0, 8'hff, r64(), r64(), TO - 1, 1, 1'b0, 1'b0, r64(), 1'b0);
    drain();
    // Response on the expiry cycle wins; one cycle later it is too late.
    do_txn(1'b0, 8'hff, r64(), r64(), 0, TO - 2, 1'b0, 1'b0, r64(), 1'b1);
    drain();
    do_txn(1'b0, 8'hff, r64(), r64(), 0, TO - 1, 1'b0, 1'b0, r64(), 1'b0);
    drain();
    // Response pulsed in the acceptance cycle is ignored.
    do_txn(1'b0, 8'hff, r64(), r64(), 2, 3, 1'b1, 1'b0, r64(), 1'b0);
    drain();

    // Reset while waiting for a response; the late response must be ignored.
    @(negedge clk);
    n = cyc;
    rst = 1'b0; core_req_i = 1'b1; core_we_i = 1'b0; core_be_i = 8'hff;
    core_addr_i = 64'h100; core_wdata_i = r64(); bus_req_ready_i = 1'b0;
    drive_rsp();
    bus_q.push_back('{1'b0, 8'hff, 64'h100, core_wdata_i, 1'b1});
    s.c = n + 12; s.d = r64(); s.e = 1'b0;
    sched.push_back(s);
    last_sched_c = s.c;
    @(negedge clk); core_req_i = 1'b0; scramble_core(); bus_req_ready_i = 1'b1; drive_rsp();
    repeat (2) begin
      @(negedge clk); bus_req_ready_i = 1'b0; drive_rsp();
    end
    @(negedge clk); rst = 1'b1; drive_rsp();
    drain();
    do_txn(1'b0, 8'hff, r64(), r64(), 1, 1, 1'b0, 1'b0, 64'hfeed_face_0bad_f00d, 1'b0);

    // Randomised traffic.
    hold = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!hold) idle(int'($urandom_range(0, 2)));
      hold = ($urandom_range(0, 5) == 0);
      rnd_txn(hold);
    end
    drain();
    idle(3);

    chk("all_completions_seen", 64'(exp_q.size()), 64'd0);
    chk("all_bus_requests_seen", 64'(bus_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
